bs_pack: RTL and testbench
==========================

# bs_pack

Parametrised deflate bit packer, the next-generation back end of `bs_top`. It accepts variable-length, LSB-first Huffman codes from the entropy coder and packs them into `DATA_WD`-bit output words. Output uses a valid/ready handshake with backpressure. On the last code it zero-pads to a byte boundary, appends the big-endian Adler-32 trailer, and closes with a partial final word carrying a byte count.

## Interface
- `DATA_WD`, 32, output word width; multiple of 8, ≥ 32.
- `CODE_WD`, 16, maximum code length; 8 ≤ `CODE_WD` ≤ `DATA_WD`.
- `LEN_WD`, `$clog2(CODE_WD+1)`, width of `len_i`.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rstn` in 1: asynchronous, active-low reset.
- `start_i` in 1: one-cycle pulse; clears the packer and enters RUN.
- `val_i` in 1: input code valid.
- `rdy_o` out 1: packer accepts a code.
- `dat_i` in `CODE_WD`: code bits; bit 0 is emitted first; bits at index ≥ `len_i` are ignored.
- `len_i` in `LEN_WD`: code length, 0..`CODE_WD`; 0 is legal (no bits).
- `lst_i` in 1: qualifies the final code of the stream.
- `adler32_done_i` in 1: pulse; captures `adler32_dat_i`.
- `adler32_dat_i` in 32: Adler-32 checksum.
- `val_o` out 1: output word valid.
- `rdy_i` in 1: sink accepts the word.
- `dat_o` out `DATA_WD`: packed word; stream byte 0 is in `[7:0]`.
- `byt_o` out `$clog2(DATA_WD/8+1)`: valid bytes in `dat_o`; equals `DATA_WD/8` except on the final word.
- `lst_o` out 1: marks the final word.
- `done_o` out 1: one-cycle pulse after the final word is accepted.

## Operation
- Storage: bit buffer `buf_r` of width `DATA_WD+CODE_WD`, plus fill count `cnt_r`. Bits at index ≥ `cnt_r` are always 0.
- Push (`val_i && rdy_o`): `buf_r[cnt_r +: len_i]` ← masked `dat_i`; `cnt_r` += `len_i`.
- Pop (`val_o && rdy_i`): `buf_r` shifts right by `DATA_WD`; `cnt_r` -= `DATA_WD`.
- Push and pop may occur in the same cycle.
- `rdy_o = (state==RUN) && (cnt_r < DATA_WD || rdy_i)`. This is a combinational path from `rdy_i`; it gives full throughput.
- `val_o`:
  - In RUN/ALN/ADL/TRL: high when `cnt_r >= DATA_WD`.
  - In FLS: high when `cnt_r > 0`.
  - `dat_o` = `buf_r[DATA_WD-1:0]`.
- Adler capture: `adler32_done_i` in any non-IDLE state latches `adler32_dat_i` and sets `adl_vld_r`. The capture may arrive before or after `lst_i`. `start_i` clears `adl_vld_r`.

State machine:
- IDLE: waits for `start_i`.
- RUN: accepts codes. A push with `lst_i` → ALN.
- ALN: waits until `cnt_r < DATA_WD`, then rounds `cnt_r` up to a multiple of 8 (pad bits are 0) → ADL.
- ADL: when `adl_vld_r` is set → TRL.
- TRL: pushes one 8-bit trailer byte per cycle when `cnt_r < DATA_WD` or a pop occurs that cycle.
  - Byte order: `adler[31:24]`, `[23:16]`, `[15:8]`, `[7:0]`.
  - After the 4th byte → FLS.
- FLS: emits the remaining bytes; FLS is always entered with `cnt_r ≥ 8`.
  - `lst_o = (cnt_r <= DATA_WD)`.
  - `byt_o = min(cnt_r, DATA_WD)/8`.
  - Unused upper bytes are 0.
  - On accept of the last word → DONE.
- DONE: `done_o` = 1 for one cycle → IDLE.
- `start_i` in any state: `buf_r` and `cnt_r` are cleared, `adl_vld_r` is cleared, state → RUN. No stale word is emitted. `start_i` has priority over a simultaneous push.

## Timing
- Reset values: every register and output is 0; state IDLE. Specifically `rdy_o`=0, `val_o`=0, `dat_o`=0, `byt_o`=0, `lst_o`=0, `done_o`=0.
- Latency: a code that completes a word gives `val_o` high the cycle after the push edge.
- `val_o`/`dat_o`/`byt_o`/`lst_o` hold stable while `rdy_i` = 0.
- `val_o` never drops without an accepted pop, except on `start_i` or reset.
- Sustained throughput is one code per cycle when `rdy_i` = 1.
- Trailer: 4 cycles minimum from entering TRL (with `adl_vld_r` already set) plus drain.
- `done_o` asserts the cycle after the final pop edge.
- `rstn` low mid-operation clears everything immediately, asynchronously.

## Test plan
- `DATA_WD`=32, `rdy_i`=1: push 8 codes of `len_i`=4 with values 1..8 → one word `dat_o`=0x87654321, `byt_o`=4, `lst_o`=0.
- Single code `len_i`=3, `dat_i`=3'b101, `lst_i`=1; `adler32_dat_i`=0x12345678 captured beforehand:
  - word 0x56341205, `byt_o`=4, `lst_o`=0;
  - then 0x00000078, `byt_o`=1, `lst_o`=1;
  - then `done_o` pulse.
- Exact fill: 32 bits of codes, then `lst_i`, Adler 0xAABBCCDD captured 20 cycles after `lst_i`:
  - code word emitted first;
  - `val_o` stays low in ADL until the capture;
  - final word 0xDDCCBBAA, `byt_o`=4, `lst_o`=1.
- Backpressure: random stream with `rdy_i` toggling pseudo-randomly (held 0 for 10 cycles at least once):
  - `rdy_o` drops while a word is pending and `rdy_i`=0;
  - outputs stay stable;
  - concatenated output bitstream equals the reference packing, with no loss or duplication.
- `start_i` mid-stream with 20 bits buffered:
  - no word emitted;
  - the next stream of 8×4-bit codes (values 1..8) yields 0x87654321.
- `rstn` pulse during TRL → all outputs 0 at once; state IDLE.
- `DATA_WD`=64, `CODE_WD`=15: random stream including `len_i`=0 codes → matches the reference packing model, final `byt_o` is correct.

Source files
------------

// File: rtl/bs_pack_if.sv
// -----------------------------------------------------------------------------
// bs_pack_if
// Bundles every bs_pack signal except clk and rstn.
//   Code input   : start_i, val_i, rdy_o, dat_i, len_i, lst_i
//   Adler input  : adler32_done_i, adler32_dat_i
//   Word output  : val_o, rdy_i, dat_o, byt_o, lst_o, done_o
// The signal names keep the packer's own _i/_o suffixes, which are seen from
// the packer's side. The slave modport is the packer. The master modport is
// the entropy coder together with the word sink.
// -----------------------------------------------------------------------------
interface bs_pack_if #(
  parameter int DATA_WD = 32,
  parameter int CODE_WD = 16
);
  localparam int LEN_WD = $clog2(CODE_WD + 1);
  localparam int BYT_WD = $clog2(DATA_WD / 8 + 1);

  logic                start_i;
  logic                val_i;
  logic                rdy_o;
  logic [CODE_WD-1:0]  dat_i;
  logic [LEN_WD-1:0]   len_i;
  logic                lst_i;
  logic                adler32_done_i;
  logic [31:0]         adler32_dat_i;
  logic                val_o;
  logic                rdy_i;
  logic [DATA_WD-1:0]  dat_o;
  logic [BYT_WD-1:0]   byt_o;
  logic                lst_o;
  logic                done_o;

  modport master (
    output start_i, val_i, dat_i, len_i, lst_i, adler32_done_i, adler32_dat_i, rdy_i,
    input  rdy_o, val_o, dat_o, byt_o, lst_o, done_o
  );

  modport slave (
    input  start_i, val_i, dat_i, len_i, lst_i, adler32_done_i, adler32_dat_i, rdy_i,
    output rdy_o, val_o, dat_o, byt_o, lst_o, done_o
  );
endinterface

// File: rtl/bs_pack.sv
// -----------------------------------------------------------------------------
// bs_pack
// Deflate bit packer. It packs LSB-first variable-length codes into DATA_WD-bit
// words. On the last code it pads the stream to a byte boundary. It then
// appends the Adler-32 checksum with the most significant byte first, and
// closes with a partial final word that carries a byte count.
//   clk  : clock, all state changes on the rising edge
//   rstn : asynchronous active-low reset
//   bus  : bs_pack_if.slave (code input, Adler capture, word output)
// -----------------------------------------------------------------------------
module bs_pack #(
  parameter int DATA_WD = 32,
  parameter int CODE_WD = 16,
  parameter int LEN_WD  = $clog2(CODE_WD + 1)
) (
  input  logic     clk,
  input  logic     rstn,
  bs_pack_if.slave bus
);
  localparam int BUF_WD = DATA_WD + CODE_WD;
  localparam int CNT_WD = $clog2(BUF_WD + 1);
  localparam int BYT_WD = $clog2(DATA_WD / 8 + 1);
  localparam logic [CNT_WD-1:0] WORD_BITS = CNT_WD'(DATA_WD);

  typedef enum logic [2:0] {
    S_IDLE, S_RUN, S_ALN, S_ADL, S_TRL, S_FLS, S_DONE
  } state_t;

  state_t              state_r;
  logic [BUF_WD-1:0]   buf_r;
  logic [CNT_WD-1:0]   cnt_r;
  logic [31:0]         adl_r;
  logic                adl_vld_r;
  logic [1:0]          trl_idx_r;

  logic                full, val_int, val, rdy, pop, push, trl_push;
  logic [LEN_WD-1:0]   len;
  logic [CODE_WD-1:0]  code_mask;
  logic [7:0]          trl_byte;
  logic [BUF_WD-1:0]   ins_bits, buf_pop, buf_nxt;
  logic [CNT_WD-1:0]   ins_len, cnt_pop, cnt_nxt, cnt_rnd;
  logic [BYT_WD-1:0]   byt;

  assign len  = bus.len_i;
  assign full = (cnt_r >= WORD_BITS);

  // In FLS the buffer may hold less than a full word, and that partial word
  // still has to leave.
  assign val_int = (state_r == S_FLS) ? (cnt_r != '0)
                 : ((state_r inside {S_RUN, S_ALN, S_ADL, S_TRL}) && full);
  // A word must not be handed out in the cycle in which start_i discards it.
  assign val      = val_int && !bus.start_i;
  assign pop      = val && bus.rdy_i;
  assign rdy      = (state_r == S_RUN) && (!full || bus.rdy_i);
  assign push     = bus.val_i && rdy;
  assign trl_push = (state_r == S_TRL) && (!full || pop);

  assign code_mask = ~({CODE_WD{1'b1}} << len);
  assign cnt_rnd   = (cnt_r + CNT_WD'(7)) & ~CNT_WD'(7);

  // NOTE: every variable written in an always_comb gets a default at the top
  // of the block. Without one, any path that skips an assignment infers a latch.
  always_comb begin
    trl_byte = adl_r[31:24];
    case (trl_idx_r)
      2'd1:    trl_byte = adl_r[23:16];
      2'd2:    trl_byte = adl_r[15:8];
      2'd3:    trl_byte = adl_r[7:0];
      default: trl_byte = adl_r[31:24];
    endcase
  end

  // Take out the outgoing word first, then append the new bits at the updated
  // fill point. This lets a push and a pop share one cycle.
  always_comb begin
    buf_pop  = buf_r;
    cnt_pop  = cnt_r;
    ins_bits = '0;
    ins_len  = '0;
    if (pop) begin
      buf_pop = buf_r >> DATA_WD;
      cnt_pop = full ? (cnt_r - WORD_BITS) : '0;
    end
    if (push) begin
      ins_bits = BUF_WD'(bus.dat_i & code_mask);
      ins_len  = CNT_WD'(len);
    end else if (trl_push) begin
      ins_bits = BUF_WD'(trl_byte);
      ins_len  = CNT_WD'(8);
    end
    buf_nxt = buf_pop | (ins_bits << cnt_pop);
    cnt_nxt = cnt_pop + ins_len;
  end

  // NOTE: all sequential state uses non-blocking assignments. A later
  // assignment in the same block overrides an earlier one, so the ALN
  // rounding below can override the default cnt_r update.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= S_IDLE;
      buf_r     <= '0;
      cnt_r     <= '0;
      adl_r     <= '0;
      adl_vld_r <= 1'b0;
      trl_idx_r <= '0;
    end else if (bus.start_i) begin
      state_r   <= S_RUN;
      buf_r     <= '0;
      cnt_r     <= '0;
      adl_vld_r <= 1'b0;
      trl_idx_r <= '0;
    end else begin
      buf_r <= buf_nxt;
      cnt_r <= cnt_nxt;
      if (bus.adler32_done_i && state_r != S_IDLE) begin
        adl_r     <= bus.adler32_dat_i;
        adl_vld_r <= 1'b1;
      end
      case (state_r)
        S_RUN: if (push && bus.lst_i) state_r <= S_ALN;
        // val_int is low here, so no pop or push changes cnt_r in this cycle.
        // The buffer bits above cnt_r are already zero, so the pad bits are
        // zero as well.
        S_ALN: if (!full) begin
          cnt_r   <= cnt_rnd;
          state_r <= S_ADL;
        end
        S_ADL: if (adl_vld_r) begin
          trl_idx_r <= '0;
          state_r   <= S_TRL;
        end
        S_TRL: if (trl_push) begin
          trl_idx_r <= trl_idx_r + 2'd1;
          if (trl_idx_r == 2'd3) state_r <= S_FLS;
        end
        S_FLS:   if (pop && cnt_r <= WORD_BITS) state_r <= S_DONE;
        S_DONE:  state_r <= S_IDLE;
        default: state_r <= state_r;
      endcase
    end
  end

  always_comb begin
    byt = '0;
    if (val) begin
      if (state_r == S_FLS && !full) byt = BYT_WD'(cnt_r >> 3);
      else                           byt = BYT_WD'(DATA_WD / 8);
    end
  end

  assign bus.rdy_o  = rdy;
  assign bus.val_o  = val;
  assign bus.dat_o  = buf_r[DATA_WD-1:0];
  assign bus.byt_o  = byt;
  assign bus.lst_o  = val && (state_r == S_FLS) && (cnt_r <= WORD_BITS);
  assign bus.done_o = (state_r == S_DONE);
endmodule

// File: tb/tb_bs_pack.sv
// -----------------------------------------------------------------------------
// tb_bs_pack
// Self-checking bench for bs_pack. Two instances are tested: DATA_WD=32 with
// CODE_WD=16 (index 0), and DATA_WD=64 with CODE_WD=15 (index 1). The
// reference model is a plain queue of stream bits. Expected words are cut from
// that queue.
// -----------------------------------------------------------------------------
module tb_bs_pack;
  logic clk  = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  bs_pack_if #(.DATA_WD(32), .CODE_WD(16)) u_if32 ();
  bs_pack_if #(.DATA_WD(64), .CODE_WD(15)) u_if64 ();

  bs_pack #(.DATA_WD(32), .CODE_WD(16)) u_dut32 (.clk(clk), .rstn(rstn), .bus(u_if32));
  bs_pack #(.DATA_WD(64), .CODE_WD(15)) u_dut64 (.clk(clk), .rstn(rstn), .bus(u_if64));

  // Stimulus, indexed by instance.
  logic [1:0]        start = '0, val = '0, lst = '0, adone = '0, rdy_in;
  logic [1:0][15:0]  dat   = '0;
  logic [1:0][4:0]   len   = '0;
  logic [1:0][31:0]  adat  = '0;

  assign u_if32.start_i        = start[0];
  assign u_if32.val_i          = val[0];
  assign u_if32.dat_i          = dat[0];
  assign u_if32.len_i          = len[0];
  assign u_if32.lst_i          = lst[0];
  assign u_if32.adler32_done_i = adone[0];
  assign u_if32.adler32_dat_i  = adat[0];
  assign u_if32.rdy_i          = rdy_in[0];
  assign u_if64.start_i        = start[1];
  assign u_if64.val_i          = val[1];
  assign u_if64.dat_i          = dat[1][14:0];
  assign u_if64.len_i          = len[1][3:0];
  assign u_if64.lst_i          = lst[1];
  assign u_if64.adler32_done_i = adone[1];
  assign u_if64.adler32_dat_i  = adat[1];
  assign u_if64.rdy_i          = rdy_in[1];

  wire [1:0]       rdy_out  = {u_if64.rdy_o,  u_if32.rdy_o};
  wire [1:0]       val_out  = {u_if64.val_o,  u_if32.val_o};
  wire [1:0]       lst_out  = {u_if64.lst_o,  u_if32.lst_o};
  wire [1:0]       done_out = {u_if64.done_o, u_if32.done_o};
  wire [1:0][63:0] dat_out  = {u_if64.dat_o, {32'h0, u_if32.dat_o}};
  wire [1:0][3:0]  byt_out  = {u_if64.byt_o, {1'b0, u_if32.byt_o}};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- sink: rdy_i generator (sole writer of rdy_in) ------------
  // mode 0: held low, 1: held high, 2: random with forced 12-cycle stalls
  int rdy_mode [2] = '{0, 0};
  initial begin
    int hold_left [2];
    int last_mode [2];
    hold_left = '{0, 0};
    last_mode = '{0, 0};
    rdy_in    = '0;
    forever begin
      @(posedge clk); #1;
      for (int s = 0; s < 2; s++) begin
        if (rdy_mode[s] == 2) begin
          if (last_mode[s] != 2) hold_left[s] = 12;
          if (hold_left[s] > 0) begin
            rdy_in[s] = 1'b0;
            hold_left[s]--;
          end else if ($urandom_range(0, 29) == 0) begin
            hold_left[s] = 10;
            rdy_in[s]    = 1'b0;
          end else begin
            rdy_in[s] = 1'($urandom_range(0, 1));
          end
        end else begin
          rdy_in[s] = (rdy_mode[s] == 1);
        end
        last_mode[s] = rdy_mode[s];
      end
    end
  end

  // ---------------- monitor: collects accepted words, checks stability -------
  typedef struct {
    logic [63:0] dat;
    int          byt;
    bit          lst;
  } word_t;

  word_t got0 [$];
  word_t got1 [$];
  int    done_cnt [2] = '{0, 0};
  logic [1:0]       prev_val = '0, prev_rdy = '0, prev_start = '0, prev_lst = '0;
  logic [1:0][63:0] prev_dat = '0;
  logic [1:0][3:0]  prev_byt = '0;

  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (rstn) begin
        if (prev_val[s] && !prev_rdy[s] && !prev_start[s]) begin
          check($sformatf("hold_val%0d", s), val_out[s], 1);
          check($sformatf("hold_dat%0d", s), dat_out[s], prev_dat[s]);
          check($sformatf("hold_byt%0d", s), byt_out[s], prev_byt[s]);
          check($sformatf("hold_lst%0d", s), lst_out[s], prev_lst[s]);
        end
        if (val_out[s] && !rdy_in[s]) check($sformatf("rdy_drop%0d", s), rdy_out[s], 0);
        if (val_out[s] && rdy_in[s]) begin
          word_t w;
          w.dat = dat_out[s];
          w.byt = int'(byt_out[s]);
          w.lst = lst_out[s];
          if (s == 0) got0.push_back(w);
          else        got1.push_back(w);
        end
        if (done_out[s]) done_cnt[s]++;
      end
      prev_val[s]   = val_out[s] && rstn;
      prev_rdy[s]   = rdy_in[s];
      prev_start[s] = start[s];
      prev_dat[s]   = dat_out[s];
      prev_byt[s]   = byt_out[s];
      prev_lst[s]   = lst_out[s];
    end
  end

  function automatic int got_size(input int s);
    if (s == 0) return got0.size();
    return got1.size();
  endfunction

  function automatic word_t got_word(input int s, input int i);
    if (s == 0) return got0[i];
    return got1[i];
  endfunction

  // ---------------- reference model: the stream as a bit queue ---------------
  bit exp_bits [$];
  int base_w = 0;
  int base_d = 0;

  task automatic model_close(input logic [31:0] a);
    while (exp_bits.size() % 8 != 0) exp_bits.push_back(1'b0);
    for (int b = 3; b >= 0; b--)
      for (int i = 0; i < 8; i++) exp_bits.push_back(a[8 * b + i]);
  endtask

  // ---------------- drivers (entered and left at posedge + 1) ----------------
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse_start(input int s);
    start[s] = 1'b1;
    @(posedge clk); #1;
    start[s] = 1'b0;
  endtask

  task automatic pulse_adler(input int s, input logic [31:0] a);
    adat[s]  = a;
    adone[s] = 1'b1;
    @(posedge clk); #1;
    adone[s] = 1'b0;
  endtask

  task automatic begin_stream(input int s);
    exp_bits.delete();
    base_w = got_size(s);
    base_d = done_cnt[s];
    pulse_start(s);
  endtask

  task automatic push(input int s, input logic [15:0] d, input int l, input bit last);
    bit ok = 1'b0;
    val[s] = 1'b1;
    dat[s] = d;
    len[s] = 5'(l);
    lst[s] = last;
    for (int i = 0; i < 2000 && !ok; i++) begin
      @(negedge clk);
      if (rdy_out[s]) begin
        ok = 1'b1;
        for (int b = 0; b < l; b++) exp_bits.push_back(d[b]);
      end
      @(posedge clk); #1;
    end
    val[s] = 1'b0;
    lst[s] = 1'b0;
    dat[s] = 16'($urandom);
    if (!ok) check("push_timeout", ok, 1);
  endtask

  task automatic wait_done(input int s, input string tag);
    int i = 0;
    while (done_cnt[s] == base_d && i < 3000) begin
      @(posedge clk); #1;
      i++;
    end
    check({tag, "_done_seen"}, done_cnt[s] != base_d, 1);
    idle(3);
    check({tag, "_done_once"}, done_cnt[s] - base_d, 1);
  endtask

  task automatic check_word(input int s, input int i, input logic [63:0] d,
                            input int b, input bit l, input string tag);
    word_t w;
    if (base_w + i >= got_size(s)) begin
      check({tag, "_missing"}, got_size(s) - base_w, i + 1);
      return;
    end
    w = got_word(s, base_w + i);
    check({tag, "_dat"}, w.dat, d);
    check({tag, "_byt"}, w.byt, b);
    check({tag, "_lst"}, w.lst, l);
  endtask

  // Compares everything collected since begin_stream with the bit-queue model.
  task automatic check_stream(input int s, input int dw, input string tag);
    int n, nw;
    wait_done(s, tag);
    n  = exp_bits.size();
    nw = (n + dw - 1) / dw;
    check({tag, "_nwords"}, got_size(s) - base_w, nw);
    for (int w = 0; w < nw && base_w + w < got_size(s); w++) begin
      logic [63:0] word = '0;
      for (int b = 0; b < dw; b++)
        if (w * dw + b < n) word[b] = exp_bits[w * dw + b];
      check_word(s, w, word, (w == nw - 1) ? (n - w * dw) / 8 : dw / 8,
                 w == nw - 1, $sformatf("%s_w%0d", tag, w));
    end
  endtask

  // ---------------- test sequence -------------------------------------------
  initial begin
    logic [31:0] adl;
    #2 rstn = 1'b0;
    #1;
    check("rst_rdy", rdy_out[0], 0);
    check("rst_val", val_out, 0);
    check("rst_dat", dat_out[0], 0);
    check("rst_byt", byt_out[0], 0);
    check("rst_lst", lst_out, 0);
    check("rst_done", done_out, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    rdy_mode = '{1, 1};
    @(posedge clk); #1;
    idle(2);

    // Eight 4-bit codes fill exactly one word.
    begin_stream(0);
    for (int i = 1; i <= 8; i++) push(0, 16'(i), 4, 1'b0);
    idle(3);
    check("pack8_nwords", got_size(0) - base_w, 1);
    check_word(0, 0, 64'h8765_4321, 4, 1'b0, "pack8");

    // One 3-bit code with junk above len_i; Adler captured before lst_i.
    begin_stream(0);
    pulse_adler(0, 32'h1234_5678);
    push(0, 16'hFFF5, 3, 1'b1);
    wait_done(0, "short");
    check("short_nwords", got_size(0) - base_w, 2);
    check_word(0, 0, 64'h5634_1205, 4, 1'b0, "short_w0");
    check_word(0, 1, 64'h0000_0078, 1, 1'b1, "short_w1");

    // Exactly 32 code bits. The Adler value arrives 20 cycles after lst_i.
    begin_stream(0);
    push(0, 16'hBEEF, 16, 1'b0);
    push(0, 16'hDEAD, 16, 1'b1);
    idle(20);
    check("exact_code_words", got_size(0) - base_w, 1);
    check("exact_adl_val_low", val_out[0], 0);
    pulse_adler(0, 32'hAABB_CCDD);
    wait_done(0, "exact");
    check("exact_nwords", got_size(0) - base_w, 2);
    check_word(0, 0, 64'hDEAD_BEEF, 4, 1'b0, "exact_w0");
    check_word(0, 1, 64'hDDCC_BBAA, 4, 1'b1, "exact_w1");

    // Random stream under backpressure. Adler arrives after lst_i.
    rdy_mode[0] = 2;
    begin_stream(0);
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
      push(0, 16'($urandom), $urandom_range(0, 16), i == 59);
    end
    idle($urandom_range(0, 30));
    adl = $urandom;
    pulse_adler(0, adl);
    model_close(adl);
    check_stream(0, 32, "bp");
    rdy_mode[0] = 1;
    idle(2);

    // start_i with 20 bits buffered discards them silently.
    begin_stream(0);
    for (int i = 0; i < 5; i++) push(0, 16'(i + 9), 4, 1'b0);
    idle(2);
    pulse_start(0);
    idle(3);
    check("restart_no_word", got_size(0) - base_w, 0);
    for (int i = 1; i <= 8; i++) push(0, 16'(i), 4, 1'b0);
    idle(3);
    check("restart_nwords", got_size(0) - base_w, 1);
    check_word(0, 0, 64'h8765_4321, 4, 1'b0, "restart");

    // 64-bit words, 15-bit codes, many zero-length codes. Adler arrives first.
    rdy_mode[1] = 2;
    begin_stream(1);
    adl = $urandom;
    pulse_adler(1, adl);
    for (int i = 0; i < 80; i++) begin
      int l = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 15);
      push(1, 16'($urandom), l, i == 79);
    end
    model_close(adl);
    check_stream(1, 64, "w64");
    rdy_mode[1] = 1;

    // Reset in the middle of the trailer: with rdy_i low, TRL stalls on a full word.
    rdy_mode[0] = 0;
    idle(2);
    begin_stream(0);
    pulse_adler(0, 32'hCAFE_F00D);
    push(0, 16'h001F, 5, 1'b1);
    idle(8);
    check("trl_stalled_val", val_out[0], 1);
    @(negedge clk); #2;
    rstn = 1'b0;
    #1;
    check("arst_val", val_out[0], 0);
    check("arst_dat", dat_out[0], 0);
    check("arst_byt", byt_out[0], 0);
    check("arst_lst", lst_out[0], 0);
    check("arst_rdy", rdy_out[0], 0);
    check("arst_done", done_out[0], 0);
    @(negedge clk); #2;
    rstn = 1'b1;
    rdy_mode[0] = 1;
    @(posedge clk); #1;
    idle(3);
    check("idle_rdy", rdy_out[0], 0);
    check("idle_val", val_out[0], 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
